// File: rtl/traffic_light_ctrl.sv
// Main/side road traffic light controller with pedestrian WALK phase and night flashing mode.
// The state advances on tick_1s. Lamps and state_o are registered from the current state, so they follow one clock later.
module traffic_light_ctrl #(
  parameter int T_MAIN_GREEN = 10,
  parameter int T_SIDE_GREEN = 6,
  parameter int T_YELLOW     = 3,
  parameter int T_ALL_RED    = 1,
  parameter int T_WALK       = 5
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       tick_half,
  input  logic       ped_req,
  input  logic       night,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       walk,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED2   = 3'd5,
    WALK   = 3'd6,
    NIGHT  = 3'd7
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_entry;
  logic       r_ped_pending;
  logic       r_blink;

  state_t     w_next;
  logic       w_tick;
  logic       w_expire;
  logic       w_change;

  function automatic logic [7:0] load_val(input state_t s);
    case (s)
      MAIN_G:         load_val = 8'(T_MAIN_GREEN - 1);
      SIDE_G:         load_val = 8'(T_SIDE_GREEN - 1);
      MAIN_Y, SIDE_Y: load_val = 8'(T_YELLOW - 1);
      RED1, RED2:     load_val = 8'(T_ALL_RED - 1);
      WALK:           load_val = 8'(T_WALK - 1);
      default:        load_val = 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] lamp_main(input state_t s, input logic blink);
    case (s)
      MAIN_G:  lamp_main = 3'b001;
      MAIN_Y:  lamp_main = 3'b010;
      NIGHT:   lamp_main = {1'b0, blink, 1'b0};
      default: lamp_main = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] lamp_side(input state_t s, input logic blink);
    case (s)
      SIDE_G:  lamp_side = 3'b001;
      SIDE_Y:  lamp_side = 3'b010;
      NIGHT:   lamp_side = {1'b0, blink, 1'b0};
      default: lamp_side = 3'b100;
    endcase
  endfunction

  // A tick landing in the entry cycle is dropped: the counter was just loaded.
  assign w_tick   = tick_1s & ~r_entry;
  assign w_expire = w_tick & (r_cnt == 8'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      MAIN_G:  if (w_expire) w_next = MAIN_Y;
      MAIN_Y:  if (w_expire) w_next = RED1;
      RED1:    if (w_expire) w_next = night ? NIGHT : SIDE_G;
      SIDE_G:  if (w_expire) w_next = SIDE_Y;
      SIDE_Y:  if (w_expire) w_next = RED2;
      RED2:    if (w_expire) w_next = night ? NIGHT : (r_ped_pending ? WALK : MAIN_G);
      WALK:    if (w_expire) w_next = MAIN_G;
      NIGHT:   if (w_tick && !night) w_next = RED2;
      default: w_next = RED2;
    endcase
  end

  assign w_change = (w_next != r_state);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state       <= MAIN_G;
      r_cnt         <= 8'(T_MAIN_GREEN - 1);
      r_entry       <= 1'b1;
      r_ped_pending <= 1'b0;
      r_blink       <= 1'b0;
      main_rgy      <= 3'b001;
      side_rgy      <= 3'b100;
      walk          <= 1'b0;
      state_o       <= 3'd0;
    end else begin
      r_state <= w_next;
      r_entry <= w_change;
      if (w_change)
        r_cnt <= load_val(w_next);
      else if (w_tick && r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;

      // Entering WALK wins over a request seen in the same cycle.
      if (w_change && w_next == WALK)
        r_ped_pending <= 1'b0;
      else if (ped_req && r_state != WALK)
        r_ped_pending <= 1'b1;

      if (w_change && w_next == NIGHT)
        r_blink <= 1'b0;
      else if (r_state == NIGHT && tick_half && !w_change)
        r_blink <= ~r_blink;

      main_rgy <= lamp_main(r_state, r_blink);
      side_rgy <= lamp_side(r_state, r_blink);
      walk     <= (r_state == WALK);
      state_o  <= r_state;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed and random bench for traffic_light_ctrl against a tick-level behavioural model.
module tb_traffic_light_ctrl;

  localparam int S_MAIN_G = 0, S_MAIN_Y = 1, S_RED1 = 2, S_SIDE_G = 3;
  localparam int S_SIDE_Y = 4, S_RED2 = 5, S_WALK = 6, S_NIGHT = 7;

  logic       clk;
  logic       reset;
  logic       tick_1s;
  logic       tick_half;
  logic       ped_req;
  logic       night;
  logic [2:0] main_rgy;
  logic [2:0] side_rgy;
  logic       walk;
  logic [2:0] state_o;

  int  checks = 0;
  int  errors = 0;
  bit  safety_en = 0;

  int  m_state;
  int  m_left;
  bit  m_ped;
  bit  m_blink;

  traffic_light_ctrl dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .tick_1s   (tick_1s),
    .tick_half (tick_half),
    .ped_req   (ped_req),
    .night     (night),
    .main_rgy  (main_rgy),
    .side_rgy  (side_rgy),
    .walk      (walk),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (safety_en) begin
      chk("safe_two_greens", {7'd0, main_rgy[0] & side_rgy[0]}, 8'd0);
      chk("safe_walk_green", {7'd0, walk & (main_rgy[0] | side_rgy[0])}, 8'd0);
    end
  end

  function automatic int mdur(input int s);
    case (s)
      S_MAIN_G: mdur = 10;
      S_SIDE_G: mdur = 6;
      S_MAIN_Y, S_SIDE_Y: mdur = 3;
      S_RED1, S_RED2: mdur = 1;
      S_WALK: mdur = 5;
      default: mdur = 0;
    endcase
  endfunction

  function automatic logic [2:0] exp_main(input int s, input bit b);
    case (s)
      S_MAIN_G: exp_main = 3'b001;
      S_MAIN_Y: exp_main = 3'b010;
      S_NIGHT:  exp_main = {1'b0, b, 1'b0};
      default:  exp_main = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input int s, input bit b);
    case (s)
      S_SIDE_G: exp_side = 3'b001;
      S_SIDE_Y: exp_side = 3'b010;
      S_NIGHT:  exp_side = {1'b0, b, 1'b0};
      default:  exp_side = 3'b100;
    endcase
  endfunction

  task automatic m_enter(input int s);
    m_state = s;
    m_left  = mdur(s);
    if (s == S_WALK)  m_ped = 0;
    if (s == S_NIGHT) m_blink = 0;
  endtask

  // One tick event at the level of the road-crossing rules, not of clock cycles.
  task automatic model_tick(input bit t1, input bit th);
    if (m_state == S_NIGHT) begin
      if (t1 && !night) m_enter(S_RED2);
      else if (th) m_blink = !m_blink;
    end else if (t1) begin
      m_left--;
      if (m_left == 0) begin
        case (m_state)
          S_MAIN_G: m_enter(S_MAIN_Y);
          S_MAIN_Y: m_enter(S_RED1);
          S_RED1:   m_enter(night ? S_NIGHT : S_SIDE_G);
          S_SIDE_G: m_enter(S_SIDE_Y);
          S_SIDE_Y: m_enter(S_RED2);
          S_RED2:   m_enter(night ? S_NIGHT : (m_ped ? S_WALK : S_MAIN_G));
          default:  m_enter(S_MAIN_G);
        endcase
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_main"},  {5'd0, main_rgy}, {5'd0, exp_main(m_state, m_blink)});
    chk({tag, "_side"},  {5'd0, side_rgy}, {5'd0, exp_side(m_state, m_blink)});
    chk({tag, "_walk"},  {7'd0, walk},     {7'd0, m_state == S_WALK});
    chk({tag, "_state"}, {5'd0, state_o},  8'(m_state));
  endtask

  task automatic step(input bit t1, input bit th);
    @(negedge clk);
    tick_1s = t1;
    tick_half = th;
    @(negedge clk);
    tick_1s = 0;
    tick_half = 0;
    model_tick(t1, th);
    @(negedge clk);
    check_outputs("step");
  endtask

  task automatic ped_pulse();
    @(negedge clk);
    ped_req = 1;
    @(negedge clk);
    ped_req = 0;
    if (m_state != S_WALK) m_ped = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    m_state = S_MAIN_G;
    m_left  = 10;
    m_ped   = 0;
    m_blink = 0;
    @(negedge clk);
    check_outputs("reset");
  endtask

  initial begin
    reset = 1; tick_1s = 0; tick_half = 0; ped_req = 0; night = 0;
    do_reset();
    safety_en = 1;
    chk("rst_main", {5'd0, main_rgy}, 8'b001);
    chk("rst_side", {5'd0, side_rgy}, 8'b100);

    // Default cycle over 33 seconds.
    for (int i = 1; i <= 33; i++) begin
      step(1, 0);
      if (i == 9)  chk("dflt_t9",  {5'd0, state_o}, 8'd0);
      if (i == 10) chk("dflt_t10", {5'd0, state_o}, 8'd1);
      if (i == 13) chk("dflt_t13", {5'd0, state_o}, 8'd2);
      if (i == 14) chk("dflt_t14", {5'd0, state_o}, 8'd3);
      if (i == 20) chk("dflt_t20", {5'd0, state_o}, 8'd4);
      if (i == 23) chk("dflt_t23", {5'd0, state_o}, 8'd5);
      if (i == 24) chk("dflt_t24", {5'd0, state_o}, 8'd0);
    end
    chk("dflt_t33", {5'd0, state_o}, 8'd0);

    // Pedestrian request during SIDE_G, then a second request inside WALK.
    do_reset();
    for (int i = 0; i < 14; i++) step(1, 0);
    ped_pulse();
    for (int i = 0; i < 10; i++) step(1, 0);
    chk("ped_walk_st", {5'd0, state_o}, 8'd6);
    chk("ped_walk_lamp", {7'd0, walk}, 8'd1);
    ped_pulse();
    for (int i = 0; i < 4; i++) step(1, 0);
    chk("ped_walk_t4", {7'd0, walk}, 8'd1);
    step(1, 0);
    chk("ped_after_walk", {5'd0, state_o}, 8'd0);
    for (int i = 0; i < 24; i++) step(1, 0);
    chk("ped_no_rewalk", {5'd0, state_o}, 8'd0);

    // Entry-cycle tick is ignored: two back-to-back tick cycles entering SIDE_G.
    do_reset();
    for (int i = 0; i < 13; i++) step(1, 0);
    @(negedge clk); tick_1s = 1;
    @(negedge clk); tick_1s = 1;
    @(negedge clk); tick_1s = 0;
    model_tick(1, 0);
    @(negedge clk);
    check_outputs("entry");
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("entry_sideg_t5", {5'd0, state_o}, 8'd3);
    step(1, 0);
    chk("entry_sidey_t6", {5'd0, state_o}, 8'd4);

    // Night mode from MAIN_G, blinking, coincident ticks on exit.
    do_reset();
    @(negedge clk); night = 1;
    for (int i = 0; i < 14; i++) step(1, 0);
    chk("night_enter", {5'd0, state_o}, 8'd7);
    chk("night_dark", {5'd0, main_rgy}, 8'b000);
    step(0, 1);
    chk("night_blink1_m", {5'd0, main_rgy}, 8'b010);
    chk("night_blink1_s", {5'd0, side_rgy}, 8'b010);
    step(0, 1);
    chk("night_blink2", {5'd0, main_rgy}, 8'b000);
    step(1, 1);
    chk("night_stay_toggle", {5'd0, side_rgy}, 8'b010);
    step(1, 0);
    chk("night_stay", {5'd0, state_o}, 8'd7);
    @(negedge clk); night = 0;
    step(1, 1);
    chk("coinc_red2", {5'd0, state_o}, 8'd5);
    chk("coinc_main_red", {5'd0, main_rgy}, 8'b100);
    step(1, 0);
    chk("night_back_main", {5'd0, state_o}, 8'd0);

    // Asynchronous reset while in WALK.
    do_reset();
    ped_pulse();
    for (int i = 0; i < 24; i++) step(1, 0);
    chk("arst_in_walk", {7'd0, walk}, 8'd1);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("arst_main", {5'd0, main_rgy}, 8'b001);
    chk("arst_side", {5'd0, side_rgy}, 8'b100);
    chk("arst_walk", {7'd0, walk}, 8'd0);
    chk("arst_state", {5'd0, state_o}, 8'd0);
    do_reset();
    for (int i = 0; i < 24; i++) step(1, 0);
    chk("arst_ped_cleared", {5'd0, state_o}, 8'd0);

    // Randomized mix of ticks, pedestrian pulses and night changes.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      int r;
      bit t1, th;
      r = $urandom_range(0, 15);
      if (r < 3) ped_pulse();
      else if (r == 3) begin
        @(negedge clk);
        night = !night;
      end
      t1 = ($urandom_range(0, 3) != 0);
      th = ($urandom_range(0, 1) != 0);
      if (!t1 && !th) th = 1;
      step(t1, th);
    end

    safety_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
